inst_decode: RTL

- ID stage of the 5-stage RV32I pipeline. Sits directly downstream of instruction fetch and consumes its registered inst/pc/branch-prediction outputs.
- Decodes RV32I, reads the register file, and generates immediates and control.
- Detects load-use hazards and drives the fetch stall controls. Resolves JAL early by driving the fetch jump path.
- Registers everything into the ID/EX pipeline register for the execute stage.

---
 rtl/inst_decode.sv | 262 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/inst_decode.sv
// RV32I decode stage: field decode, RF read, load-use hazard detection,
// early JAL redirect and the ID/EX pipeline register feeding execute.
module inst_decode #(
    parameter int RF_ADDR_W = 5,
    parameter int XLEN      = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [31:0]          inst_i,
    input  logic [XLEN-1:0]      pc_i,
    input  logic                 branch_pred_i,
    input  logic                 ex_stall_i,
    input  logic                 ex_flush_i,
    input  logic                 ex_mem_read_i,
    input  logic [RF_ADDR_W-1:0] ex_rd_i,
    output logic [RF_ADDR_W-1:0] rs1_addr_o,
    output logic [RF_ADDR_W-1:0] rs2_addr_o,
    input  logic [XLEN-1:0]      rs1_data_i,
    input  logic [XLEN-1:0]      rs2_data_i,
    output logic                 pc_stall_o,
    output logic                 if_stall_o,
    output logic                 if_flush_o,
    output logic                 jmp_o,
    output logic [XLEN-1:0]      pc_jmp_o,
    output logic [XLEN-1:0]      pc_o,
    output logic [XLEN-1:0]      rs1_data_o,
    output logic [XLEN-1:0]      rs2_data_o,
    output logic [RF_ADDR_W-1:0] rs1_o,
    output logic [RF_ADDR_W-1:0] rs2_o,
    output logic [XLEN-1:0]      imm_o,
    output logic [RF_ADDR_W-1:0] rd_o,
    output logic [3:0]           alu_op_o,
    output logic                 alu_src_o,
    output logic                 mem_read_o,
    output logic                 mem_write_o,
    output logic [2:0]           funct3_o,
    output logic                 reg_write_o,
    output logic                 branch_o,
    output logic                 branch_pred_o,
    output logic                 jalr_o,
    output logic                 link_o,
    output logic                 auipc_o,
    output logic                 illegal_o
);

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [3:0] ALU_ADD   = 4'd0;
    localparam logic [3:0] ALU_SUB   = 4'd1;
    localparam logic [3:0] ALU_SLL   = 4'd2;
    localparam logic [3:0] ALU_SLT   = 4'd3;
    localparam logic [3:0] ALU_SLTU  = 4'd4;
    localparam logic [3:0] ALU_XOR   = 4'd5;
    localparam logic [3:0] ALU_SRL   = 4'd6;
    localparam logic [3:0] ALU_SRA   = 4'd7;
    localparam logic [3:0] ALU_OR    = 4'd8;
    localparam logic [3:0] ALU_AND   = 4'd9;
    localparam logic [3:0] ALU_PASSB = 4'd10;

    typedef struct packed {
        logic [XLEN-1:0]      pc;
        logic [XLEN-1:0]      rs1_data;
        logic [XLEN-1:0]      rs2_data;
        logic [XLEN-1:0]      imm;
        logic [RF_ADDR_W-1:0] rs1;
        logic [RF_ADDR_W-1:0] rs2;
        logic [RF_ADDR_W-1:0] rd;
        logic [3:0]           alu_op;
        logic                 alu_src;
        logic                 mem_read;
        logic                 mem_write;
        logic [2:0]           funct3;
        logic                 reg_write;
        logic                 branch;
        logic                 branch_pred;
        logic                 jalr;
        logic                 link;
        logic                 auipc;
        logic                 illegal;
    } idex_t;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [4:0] rd_f;
    logic       f7b5;
    logic signed [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

    assign opcode = inst_i[6:0];
    assign funct3 = inst_i[14:12];
    assign rd_f   = inst_i[11:7];
    assign f7b5   = inst_i[30];

    assign imm_i = {{20{inst_i[31]}}, inst_i[31:20]};
    assign imm_s = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
    assign imm_b = {{19{inst_i[31]}}, inst_i[31], inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};
    assign imm_u = {inst_i[31:12], 12'b0};
    assign imm_j = {{11{inst_i[31]}}, inst_i[31], inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0};

    assign rs1_addr_o = RF_ADDR_W'(inst_i[19:15]);
    assign rs2_addr_o = RF_ADDR_W'(inst_i[24:20]);

    // funct3 -> ALU op shared by OP and OP-IMM; only OP turns ADD into SUB
    logic [3:0] alu_f3;
    always_comb begin
        alu_f3 = ALU_ADD;
        case (funct3)
            3'd0: alu_f3 = ALU_ADD;
            3'd1: alu_f3 = ALU_SLL;
            3'd2: alu_f3 = ALU_SLT;
            3'd3: alu_f3 = ALU_SLTU;
            3'd4: alu_f3 = ALU_XOR;
            3'd5: alu_f3 = f7b5 ? ALU_SRA : ALU_SRL;
            3'd6: alu_f3 = ALU_OR;
            3'd7: alu_f3 = ALU_AND;
            default: alu_f3 = ALU_ADD;
        endcase
    end

    idex_t dec;
    logic  use_rs1, use_rs2, legal, is_jal;

    always_comb begin
        dec             = '0;
        use_rs1         = 1'b0;
        use_rs2         = 1'b0;
        legal           = 1'b1;
        is_jal          = 1'b0;
        dec.pc          = pc_i;
        dec.rs1_data    = rs1_data_i;
        dec.rs2_data    = rs2_data_i;
        dec.rs1         = rs1_addr_o;
        dec.rs2         = rs2_addr_o;
        dec.funct3      = funct3;
        dec.branch_pred = branch_pred_i;
        case (opcode)
            OPC_OP: begin
                use_rs1 = 1'b1; use_rs2 = 1'b1;
                dec.alu_op    = (funct3 == 3'd0 && f7b5) ? ALU_SUB : alu_f3;
                dec.reg_write = 1'b1;
            end
            OPC_OPIMM: begin
                use_rs1 = 1'b1;
                dec.alu_op    = alu_f3;
                dec.alu_src   = 1'b1;
                dec.imm       = XLEN'(imm_i);
                dec.reg_write = 1'b1;
            end
            OPC_LOAD: begin
                use_rs1 = 1'b1;
                dec.alu_src   = 1'b1;
                dec.imm       = XLEN'(imm_i);
                dec.mem_read  = 1'b1;
                dec.reg_write = 1'b1;
            end
            OPC_STORE: begin
                use_rs1 = 1'b1; use_rs2 = 1'b1;
                dec.alu_src   = 1'b1;
                dec.imm       = XLEN'(imm_s);
                dec.mem_write = 1'b1;
            end
            OPC_BRANCH: begin
                use_rs1 = 1'b1; use_rs2 = 1'b1;
                dec.alu_op = ALU_SUB;
                dec.imm    = XLEN'(imm_b);
                dec.branch = 1'b1;
            end
            OPC_LUI: begin
                dec.alu_op    = ALU_PASSB;
                dec.alu_src   = 1'b1;
                dec.imm       = XLEN'(imm_u);
                dec.reg_write = 1'b1;
            end
            OPC_AUIPC: begin
                dec.alu_src   = 1'b1;
                dec.imm       = XLEN'(imm_u);
                dec.auipc     = 1'b1;
                dec.reg_write = 1'b1;
            end
            OPC_JAL: begin
                is_jal = 1'b1;
                dec.alu_src   = 1'b1;
                dec.imm       = XLEN'(imm_j);
                dec.link      = 1'b1;
                dec.reg_write = 1'b1;
            end
            OPC_JALR: begin
                use_rs1 = 1'b1;
                dec.alu_src   = 1'b1;
                dec.imm       = XLEN'(imm_i);
                dec.jalr      = 1'b1;
                dec.link      = 1'b1;
                dec.reg_write = 1'b1;
            end
            default: legal = 1'b0;
        endcase
        // x0 is never written; rd_o stays 0 for non-writers so forwarding never matches
        if (rd_f == 5'd0)
            dec.reg_write = 1'b0;
        if (dec.reg_write)
            dec.rd = RF_ADDR_W'(rd_f);
    end

    logic hazard, jal_go;

    assign hazard = ex_mem_read_i && (ex_rd_i != '0) &&
                    ((use_rs1 && ex_rd_i == rs1_addr_o) || (use_rs2 && ex_rd_i == rs2_addr_o));
    assign jal_go = is_jal && !hazard && !ex_flush_i && !ex_stall_i;

    assign pc_stall_o = ex_stall_i || (hazard && !ex_flush_i);
    assign if_stall_o = pc_stall_o;
    assign if_flush_o = !ex_stall_i && (ex_flush_i || jal_go);
    assign jmp_o      = jal_go;
    assign pc_jmp_o   = pc_i + XLEN'(imm_j);

    idex_t idex_d, idex_q;

    always_comb begin
        idex_d = '0;
        if (ex_flush_i || hazard)
            idex_d = '0;
        else if (!legal)
            idex_d.illegal = 1'b1;
        else
            idex_d = dec;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            idex_q <= '0;
        else if (!ex_stall_i)
            idex_q <= idex_d;
    end

    assign pc_o          = idex_q.pc;
    assign rs1_data_o    = idex_q.rs1_data;
    assign rs2_data_o    = idex_q.rs2_data;
    assign rs1_o         = idex_q.rs1;
    assign rs2_o         = idex_q.rs2;
    assign imm_o         = idex_q.imm;
    assign rd_o          = idex_q.rd;
    assign alu_op_o      = idex_q.alu_op;
    assign alu_src_o     = idex_q.alu_src;
    assign mem_read_o    = idex_q.mem_read;
    assign mem_write_o   = idex_q.mem_write;
    assign funct3_o      = idex_q.funct3;
    assign reg_write_o   = idex_q.reg_write;
    assign branch_o      = idex_q.branch;
    assign branch_pred_o = idex_q.branch_pred;
    assign jalr_o        = idex_q.jalr;
    assign link_o        = idex_q.link;
    assign auipc_o       = idex_q.auipc;
    assign illegal_o     = idex_q.illegal;

endmodule
